// File: rtl/fib_rec_n.sv
// Tests whether a packed-BCD operand is a Fibonacci number by converting it to
// binary and walking the sequence. Define FIB_REC_INDEX_EN to report the index.
module fib_rec_n #(
    parameter int DIGITS = 2,
    parameter int BW     = $clog2(10**DIGITS) + 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  is_fib,
    output logic                  bcd_err,
    output logic [7:0]            fib_idx
);

    typedef enum logic [1:0] {IDLE, CONV, GEN, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(DIGITS - 1);

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] op_q, op_d;
    logic [BW-1:0]       value_q, value_d;
    logic [BW-1:0]       a_q, a_d;
    logic [BW-1:0]       b_q, b_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                is_fib_q, is_fib_d;
    logic                bcd_err_q, bcd_err_d;
`ifdef FIB_REC_INDEX_EN
    logic [7:0]          n_q, n_d;
    logic [7:0]          fib_idx_q, fib_idx_d;
`endif

    function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] bcd);
        logic bad_v;
        bad_v = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'd9) bad_v = 1'b1;
        end
        return bad_v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = has_bad_digit(bcd_in) ? DONE : CONV;
            CONV:    if (cnt_q == CNT_LAST) state_d = GEN;
            GEN:     if (a_q >= value_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Datapath: operand latch, digit-serial conversion, sequence walk, result flags.
    always_comb begin
        op_d      = op_q;
        value_d   = value_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        is_fib_d  = is_fib_q;
        bcd_err_d = bcd_err_q;
`ifdef FIB_REC_INDEX_EN
        n_d       = n_q;
        fib_idx_d = fib_idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d      = bcd_in;
                    value_d   = '0;
                    cnt_d     = '0;
                    is_fib_d  = 1'b0;
                    bcd_err_d = has_bad_digit(bcd_in);
`ifdef FIB_REC_INDEX_EN
                    fib_idx_d = '0;
`endif
                end
            end
            CONV: begin
                value_d = (value_q << 3) + (value_q << 1) + BW'(op_q[4*DIGITS-1 -: 4]);
                op_d    = op_q << 4;
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    a_d = '0;
                    b_d = BW'(1);
`ifdef FIB_REC_INDEX_EN
                    n_d = '0;
`endif
                end
            end
            GEN: begin
                if (a_q == value_q) begin
                    is_fib_d  = 1'b1;
`ifdef FIB_REC_INDEX_EN
                    fib_idx_d = n_q;
`endif
                end else if (a_q < value_q) begin
                    a_d = b_q;
                    b_d = a_q + b_q;
`ifdef FIB_REC_INDEX_EN
                    n_d = n_q + 8'd1;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            value_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            is_fib_q  <= 1'b0;
            bcd_err_q <= 1'b0;
`ifdef FIB_REC_INDEX_EN
            n_q       <= '0;
            fib_idx_q <= '0;
`endif
        end else begin
            op_q      <= op_d;
            value_q   <= value_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            is_fib_q  <= is_fib_d;
            bcd_err_q <= bcd_err_d;
`ifdef FIB_REC_INDEX_EN
            n_q       <= n_d;
            fib_idx_q <= fib_idx_d;
`endif
        end
    end

    assign is_fib  = is_fib_q;
    assign bcd_err = bcd_err_q;
`ifdef FIB_REC_INDEX_EN
    assign fib_idx = fib_idx_q;
`else
    assign fib_idx = 8'd0;
`endif

endmodule

// File: tb/tb_fib_rec_n.sv
// Directed bench for fib_rec_n with DIGITS=2: latency, result flags, reset
// behaviour and start handling; index expectations follow FIB_REC_INDEX_EN.
module tb_fib_rec_n;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] bcd_in;
    logic       busy, done, is_fib, bcd_err;
    logic [7:0] fib_idx;
    int         total = 0;
    int         bad = 0;
    int         cyc;
    int         pulses;

    always #5 clk = ~clk;

    fib_rec_n #(.DIGITS(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .bcd_in  (bcd_in),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .is_fib  (is_fib),
        .bcd_err (bcd_err),
        .fib_idx (fib_idx)
    );

    function automatic int exp_idx(input int k);
`ifdef FIB_REC_INDEX_EN
        return k;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Called #1 after the accept edge; returns the cycle offset of done from T.
    task automatic wait_done(output int c);
        c = 1;
        while (done !== 1'b1 && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
    endtask

    // Starts from an IDLE cycle (#1 after an edge); that cycle is T.
    task automatic run(input logic [7:0] v, input int ecyc, input int efib,
                       input int eerr, input int eidx, input string tag);
        int c;
        bcd_in = v;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        bcd_in = ~v;
        if (ecyc > 1) check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(c);
        check({tag, "_lat"},  32'(c),       32'(ecyc));
        check({tag, "_fib"},  32'(is_fib),  32'(efib));
        check({tag, "_err"},  32'(bcd_err), 32'(eerr));
        check({tag, "_idx"},  32'(fib_idx), 32'(eidx));
        check({tag, "_excl"}, 32'(is_fib & bcd_err), 32'd0);
        @(posedge clk); #1;
        check({tag, "_done1"}, 32'(done),   32'd0);
        check({tag, "_idle"},  32'(busy),   32'd0);
        check({tag, "_hold"},  32'(is_fib), 32'(efib));
        check({tag, "_holdi"}, 32'(fib_idx), 32'(eidx));
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        bcd_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  32'(busy),    32'd0);
        check("rst_done",  32'(done),    32'd0);
        check("rst_fib",   32'(is_fib),  32'd0);
        check("rst_err",   32'(bcd_err), 32'd0);
        check("rst_idx",   32'(fib_idx), 32'd0);

        // Reset wins over start in the same cycle.
        start  = 1'b1;
        bcd_in = 8'h13;
        @(posedge clk); #1;
        check("rst_prio_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        check("idle_stay", 32'(busy), 32'd0);

        run(8'h00, 4,  1, 0, exp_idx(0),  "v00");
        run(8'h13, 11, 1, 0, exp_idx(7),  "v13");
        run(8'h04, 9,  0, 0, 0,           "v04");
        run(8'h89, 15, 1, 0, exp_idx(11), "v89");
        run(8'h99, 16, 0, 0, 0,           "v99");
        run(8'h1A, 1,  0, 1, 0,           "v1A");
        run(8'h01, 5,  1, 0, exp_idx(1),  "v01");
        run(8'h55, 14, 1, 0, exp_idx(10), "v55");
        run(8'hA0, 1,  0, 1, 0,           "vA0");
        run(8'h89, 15, 1, 0, exp_idx(11), "v89b");

        // Reset during GEN: accept at T, reset high in cycle T+5.
        bcd_in = 8'h89;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mr_busy", 32'(busy),    32'd0);
        check("mr_done", 32'(done),    32'd0);
        check("mr_fib",  32'(is_fib),  32'd0);
        check("mr_err",  32'(bcd_err), 32'd0);
        check("mr_idx",  32'(fib_idx), 32'd0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        check("mr_nodone", 32'(pulses), 32'd0);
        check("mr_idle",   32'(busy),   32'd0);

        // start held high throughout busy: one result, no restart.
        bcd_in = 8'h04;
        start  = 1'b1;
        @(posedge clk); #1;
        wait_done(cyc);
        check("hold_lat", 32'(cyc),    32'd9);
        check("hold_fib", 32'(is_fib), 32'd0);
        // Keep start high into the first IDLE cycle: back-to-back accept.
        bcd_in = 8'h13;
        @(posedge clk); #1;
        check("b2b_idle", 32'(busy), 32'd0);
        check("b2b_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        start  = 1'b0;
        bcd_in = 8'h00;
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done(cyc);
        check("b2b_lat", 32'(cyc),     32'd11);
        check("b2b_fib", 32'(is_fib),  32'd1);
        check("b2b_idx", 32'(fib_idx), 32'(exp_idx(7)));
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        check("b2b_single", 32'(pulses), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
